// File: rtl/multi_vc_buffer.sv
// rtl/multi_vc_buffer.sv - multi-VC first-word-fall-through flit buffer; optional count_o under BUFFER_OCCUPANCY_EN
module multi_vc_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 8,
  parameter int NUM_VC     = 2,
  localparam int VC_BITS   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  write_i,
  input  logic [VC_BITS-1:0]    write_vc_i,
  input  logic                  read_i,
  input  logic [VC_BITS-1:0]    read_vc_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [NUM_VC-1:0]     full_o,
  output logic [NUM_VC-1:0]     empty_o
`ifdef BUFFER_OCCUPANCY_EN
  ,
  output logic [NUM_VC*$clog2(SIZE+1)-1:0] count_o
`endif
);

  localparam int                  PTR_BITS = $clog2(SIZE);
  localparam logic [VC_BITS:0]    NUM_VC_L = (VC_BITS+1)'(NUM_VC);
  localparam logic [PTR_BITS-1:0] LAST_PTR = PTR_BITS'(SIZE - 1);

  logic [DATA_WIDTH-1:0] mem_q    [NUM_VC][SIZE];
  logic [PTR_BITS-1:0]   rd_ptr_q [NUM_VC];
  logic [PTR_BITS-1:0]   rd_ptr_d [NUM_VC];
  logic [PTR_BITS-1:0]   wr_ptr_q [NUM_VC];
  logic [PTR_BITS-1:0]   wr_ptr_d [NUM_VC];
  logic [NUM_VC-1:0]     full_q, full_d;
  logic [NUM_VC-1:0]     empty_q, empty_d;
  logic [NUM_VC-1:0]     wr_ok, rd_ok;
  logic                  wr_in_range, rd_in_range;
  logic [VC_BITS-1:0]    rd_vc_sel;

  // Circular increment; SIZE need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_BITS'(1);
  endfunction

  assign wr_in_range = ({1'b0, write_vc_i} < NUM_VC_L);
  assign rd_in_range = ({1'b0, read_vc_i} < NUM_VC_L);

  // Out-of-range read VC falls back to VC0 so the mux never indexes past the array.
  assign rd_vc_sel = rd_in_range ? read_vc_i : '0;
  assign data_o    = mem_q[rd_vc_sel][rd_ptr_q[rd_vc_sel]];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

  // Decode which VC (if any) accepts the write and the read this cycle.
  always_comb begin
    wr_ok = '0;
    rd_ok = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ok[v] = write_i && wr_in_range && (write_vc_i == VC_BITS'(v)) && !full_q[v];
      rd_ok[v] = read_i  && rd_in_range && (read_vc_i  == VC_BITS'(v)) && !empty_q[v];
    end
  end

  // Per-VC pointer and flag next state; a simultaneous read+write leaves the flags alone.
  always_comb begin
    full_d  = full_q;
    empty_d = empty_q;
    for (int v = 0; v < NUM_VC; v++) begin
      rd_ptr_d[v] = rd_ptr_q[v];
      wr_ptr_d[v] = wr_ptr_q[v];
      case ({wr_ok[v], rd_ok[v]})
        2'b10: begin
          wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
          full_d[v]   = (ptr_inc(wr_ptr_q[v]) == rd_ptr_q[v]);
          empty_d[v]  = 1'b0;
        end
        2'b01: begin
          rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
          empty_d[v]  = (ptr_inc(rd_ptr_q[v]) == wr_ptr_q[v]);
          full_d[v]   = 1'b0;
        end
        2'b11: begin
          wr_ptr_d[v] = ptr_inc(wr_ptr_q[v]);
          rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
        end
        default: ;
      endcase
    end
  end

  // Pointer and flag registers; reset empties every VC and wins over any request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
      end
      full_q  <= '0;
      empty_q <= '1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Flit storage is not reset; accepted writes land at the VC's write pointer.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (rst && wr_ok[v]) begin
        mem_q[v][wr_ptr_q[v]] <= data_i;
      end
    end
  end

`ifdef BUFFER_OCCUPANCY_EN
  localparam int CNT_BITS = $clog2(SIZE + 1);

  logic [CNT_BITS-1:0] count_q [NUM_VC];

  // Occupancy counters track write-only and read-only updates per VC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) count_q[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        case ({wr_ok[v], rd_ok[v]})
          2'b10:   count_q[v] <= count_q[v] + CNT_BITS'(1);
          2'b01:   count_q[v] <= count_q[v] - CNT_BITS'(1);
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_count
    assign count_o[g*CNT_BITS +: CNT_BITS] = count_q[g];
  end
`endif

endmodule

// File: tb/tb_multi_vc_buffer.sv
// tb/tb_multi_vc_buffer.sv - randomized and directed self-checking bench for multi_vc_buffer
module tb_multi_vc_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (16-bit, SIZE 8, 2 VCs)
  logic        rst_a, wr_a, rd_a;
  logic [0:0]  wvc_a, rvc_a;
  logic [15:0] din_a, dout_a;
  logic [1:0]  full_a, empty_a;
  // DUT B: SIZE 5, 3 VCs
  logic        rst_b, wr_b, rd_b;
  logic [1:0]  wvc_b, rvc_b;
  logic [15:0] din_b, dout_b;
  logic [2:0]  full_b, empty_b;
`ifdef BUFFER_OCCUPANCY_EN
  logic [7:0]  cnt_a;
  logic [8:0]  cnt_b;
`endif

  multi_vc_buffer dut_a (
    .clk(clk), .rst(rst_a), .data_i(din_a), .write_i(wr_a), .write_vc_i(wvc_a),
    .read_i(rd_a), .read_vc_i(rvc_a), .data_o(dout_a), .full_o(full_a), .empty_o(empty_a)
`ifdef BUFFER_OCCUPANCY_EN
    , .count_o(cnt_a)
`endif
  );

  multi_vc_buffer #(.DATA_WIDTH(16), .SIZE(5), .NUM_VC(3)) dut_b (
    .clk(clk), .rst(rst_b), .data_i(din_b), .write_i(wr_b), .write_vc_i(wvc_b),
    .read_i(rd_b), .read_vc_i(rvc_b), .data_o(dout_b), .full_o(full_b), .empty_o(empty_b)
`ifdef BUFFER_OCCUPANCY_EN
    , .count_o(cnt_b)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one FIFO queue per (dut, vc)
  logic [15:0] mq [2][4][$];
  int sz [2] = '{8, 5};
  int nv [2] = '{2, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input int d, input int rvc);
    logic [31:0] ef, ee, f, e;
    ef = '0;
    ee = '0;
    for (int v = 0; v < nv[d]; v++) begin
      ef[v] = (mq[d][v].size() == sz[d]);
      ee[v] = (mq[d][v].size() == 0);
    end
    f = (d == 0) ? 32'(full_a)  : 32'(full_b);
    e = (d == 0) ? 32'(empty_a) : 32'(empty_b);
    check(d == 0 ? "a_full" : "b_full", f, ef);
    check(d == 0 ? "a_empty" : "b_empty", e, ee);
    if (rvc < nv[d] && mq[d][rvc].size() > 0)
      check(d == 0 ? "a_data" : "b_data", (d == 0) ? 32'(dout_a) : 32'(dout_b), 32'(mq[d][rvc][0]));
`ifdef BUFFER_OCCUPANCY_EN
    for (int v = 0; v < nv[d]; v++)
      check(d == 0 ? "a_count" : "b_count",
            (d == 0) ? 32'(cnt_a[v*4 +: 4]) : 32'(cnt_b[v*3 +: 3]), 32'(mq[d][v].size()));
`endif
  endtask

  // One clock cycle on DUT d: drive at the falling edge, check, clock, update the model.
  task automatic cyc(input int d, input bit rs, input bit w, input int wvc,
                     input bit r, input int rvc, input logic [15:0] din);
    bit wok, rok;
    rst_a = 1'b1; wr_a = 1'b0; rd_a = 1'b0;
    rst_b = 1'b1; wr_b = 1'b0; rd_b = 1'b0;
    if (d == 0) begin
      rst_a = rs; wr_a = w; wvc_a = wvc[0:0]; rd_a = r; rvc_a = rvc[0:0]; din_a = din;
    end else begin
      rst_b = rs; wr_b = w; wvc_b = wvc[1:0]; rd_b = r; rvc_b = rvc[1:0]; din_b = din;
    end
    #1;
    check_state(d, rvc);
    wok = w && (wvc < nv[d]) && (mq[d][wvc].size() < sz[d]);
    rok = r && (rvc < nv[d]) && (mq[d][rvc].size() > 0);
    @(posedge clk);
    if (!rs) begin
      for (int v = 0; v < 4; v++) mq[d][v].delete();
    end else begin
      if (rok) void'(mq[d][rvc].pop_front());
      if (wok) mq[d][wvc].push_back(din);
    end
    @(negedge clk);
  endtask

  task automatic wr(input int d, input int vc, input logic [15:0] din);
    cyc(d, 1'b1, 1'b1, vc, 1'b0, vc, din);
  endtask

  task automatic rd(input int d, input int vc);
    cyc(d, 1'b1, 1'b0, 0, 1'b1, vc, 16'h0);
  endtask

  task automatic idle(input int d, input int vc);
    cyc(d, 1'b1, 1'b0, 0, 1'b0, vc, 16'h0);
  endtask

  initial begin
    rst_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0; wvc_a = '0; rvc_a = '0; din_a = '0;
    rst_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; wvc_b = '0; rvc_b = '0; din_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    check("reset_full_a", 32'(full_a), 32'h0);
    check("reset_empty_a", 32'(empty_a), 32'h3);
    check("reset_empty_b", 32'(empty_b), 32'h7);

    // Fill VC0 to full, overflow write dropped, drain in order
    for (int i = 1; i <= 8; i++) wr(0, 0, 16'(i));
    #1 check("fill_full_a", 32'(full_a), 32'h1);
    wr(0, 0, 16'hFFFF);
    for (int i = 1; i <= 8; i++) begin
      rvc_a = 1'b0;
      #1 check("drain_data", 32'(dout_a), 32'(i));
      rd(0, 0);
    end
    #1 check("drain_empty_a", 32'(empty_a), 32'h3);

    // Interleaved streams, then read VC1 before VC0
    for (int i = 0; i < 4; i++) begin
      wr(0, 0, 16'hA000 + 16'(i));
      wr(0, 1, 16'hB000 + 16'(i));
    end
    for (int i = 0; i < 4; i++) rd(0, 1);
    for (int i = 0; i < 4; i++) rd(0, 0);

    // Steady state: 3 flits, simultaneous read+write across the wrap
    for (int i = 0; i < 3; i++) wr(0, 0, 16'hC000 + 16'(i));
    for (int i = 0; i < 10; i++) cyc(0, 1'b1, 1'b1, 0, 1'b1, 0, 16'hC100 + 16'(i));
    for (int i = 0; i < 3; i++) rd(0, 0);

    // Empty VC0 with read+write: write wins, no bypass
    cyc(0, 1'b1, 1'b1, 0, 1'b1, 0, 16'h1234);
    rvc_a = 1'b0;
    #1 check("rw_empty_flag", 32'(empty_a[0]), 32'h0);
    check("rw_empty_data", 32'(dout_a), 32'h1234);
    for (int i = 0; i < 7; i++) wr(0, 0, 16'hD000 + 16'(i));
    cyc(0, 1'b1, 1'b1, 0, 1'b1, 0, 16'hEEEE);
    #1 check("rw_full_flag", 32'(full_a[0]), 32'h0);
    check("rw_full_head", 32'(dout_a), 32'hD000);
    for (int i = 0; i < 7; i++) rd(0, 0);

    // DUT B: wrap on VC2, out-of-range VC 3 ignored
    for (int i = 0; i < 3; i++) wr(1, 2, 16'h2000 + 16'(i));
    for (int i = 3; i < 7; i++) cyc(1, 1'b1, 1'b1, 2, 1'b1, 2, 16'h2000 + 16'(i));
    wr(1, 3, 16'h3333);
    rd(1, 3);
    for (int i = 0; i < 3; i++) rd(1, 2);
    idle(1, 2);

    // Mid-operation reset with a concurrent write, then a dropped read
    for (int i = 0; i < 4; i++) begin
      wr(0, 0, 16'h5000 + 16'(i));
      wr(0, 1, 16'h6000 + 16'(i));
    end
    cyc(0, 1'b0, 1'b1, 0, 1'b0, 0, 16'h7777);
    #1 check("post_reset_full", 32'(full_a), 32'h0);
    check("post_reset_empty", 32'(empty_a), 32'h3);
    rd(0, 0);
    idle(0, 0);

    // Randomized traffic against the queue model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 400; i++) begin
        cyc(d, ($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, d == 0 ? 1 : 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, d == 0 ? 1 : 3)), 16'($urandom));
      end
      idle(d, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_vc_buffer.md
MULTI_VC_BUFFER -- requirements
Module: multi_vc_buffer

Interface
REQ-001 Parameters SHALL be DATA_WIDTH, default 16, flit width in bits.
REQ-002 Parameters SHALL include SIZE, default 8, flit slots per virtual channel (VC); any integer >= 2, not necessarily a power of two.
REQ-003 Parameters SHALL include NUM_VC, default 2, number of independent VC queues (>= 1); VC_BITS = max(1, ceil(log2(NUM_VC))) is derived, not settable.
REQ-004 Ports, in order:
  - clk  input  1  clock; one clock, all logic on rising edge.
  - rst  input  1  reset; synchronous, active-low.
  - data_i  input  DATA_WIDTH  flit to enqueue.
  - write_i  input  1  enqueue request.
  - write_vc_i  input  VC_BITS  target VC of write.
  - read_i  input  1  dequeue request.
  - read_vc_i  input  VC_BITS  source VC of read.
  - data_o  output  DATA_WIDTH  head flit of VC read_vc_i.
  - full_o  output  NUM_VC  per-VC full flag, registered.
  - empty_o  output  NUM_VC  per-VC empty flag, registered.

Function
REQ-005 Each VC SHALL be an independent circular queue of SIZE x DATA_WIDTH entries with its own read pointer, write pointer, full flag and empty flag.
REQ-006 data_o SHALL combinationally show the entry at the read pointer of VC read_vc_i (first-word fall-through, zero-cycle read latency); its value when that VC is empty is don't-care.
REQ-007 A write SHALL be accepted iff write_i=1, write_vc_i < NUM_VC and full_o[write_vc_i]=0 at the clock edge; the flit is stored at that VC's write pointer and the pointer advances.
REQ-008 A read SHALL be accepted iff read_i=1, read_vc_i < NUM_VC and empty_o[read_vc_i]=0 at the clock edge; that VC's read pointer advances.
REQ-009 Requests failing REQ-007/REQ-008 (full, empty, out-of-range VC) SHALL be dropped silently, with no state change for that request.
REQ-010 Pointers SHALL wrap from SIZE-1 to 0.
REQ-011 Accepted read and accepted write on different VCs SHALL each update only their own VC.
REQ-012 Accepted read and accepted write on the same VC SHALL, in one cycle:
  - advance both pointers;
  - leave full_o and empty_o of that VC unchanged.
REQ-013 Same VC empty with read and write both asserted:
  - the write SHALL be accepted and the read dropped;
  - the VC SHALL become non-empty;
  - no write-to-read bypass.
REQ-014 Same VC full with read and write both asserted:
  - the read SHALL be accepted and the write dropped;
  - the VC SHALL become non-full.
REQ-015 After a write-only update, full SHALL be set iff the next write pointer equals the read pointer; empty SHALL be cleared.
REQ-016 After a read-only update, empty SHALL be set iff the next read pointer equals the write pointer; full SHALL be cleared.
REQ-017 Flag updates SHALL be visible on full_o/empty_o in the cycle after the accepting edge.

Reset
REQ-018 While rst=0 at a rising edge, all pointers SHALL clear to 0, full_o to all-0 and empty_o to all-1; reset SHALL override any concurrent read or write.
REQ-019 Storage array contents SHALL NOT be reset.
REQ-020 A reset asserted mid-operation SHALL discard all queued flits in every VC.

Configuration
REQ-021 With macro BUFFER_OCCUPANCY_EN defined, output count_o (NUM_VC x CNT_BITS, CNT_BITS = ceil(log2(SIZE+1)), VC k at bits [k*CNT_BITS +: CNT_BITS]) SHALL be present.
REQ-022 Under BUFFER_OCCUPANCY_EN, count_o SHALL be registered, reset to 0, +1 per write-only update, -1 per read-only update, and unchanged on simultaneous update.
REQ-023 Without BUFFER_OCCUPANCY_EN, port count_o and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-024 Reset, then write VC0 with 0x0001..0x0008 (defaults) -> full_o=2'b01 after the 8th write; a 9th write of 0xFFFF is dropped; 8 reads return 0x0001..0x0008 in order; then empty_o=2'b11.
REQ-025 Interleave writes to VC0 (0xA000+i) and VC1 (0xB000+i), 4 each -> reads of VC1 then VC0 return each stream in order, with no cross-VC mixing.
REQ-026 VC0 holding 3 flits, read and write VC0 for 10 cycles -> flags constant, count_o[VC0]=3 (if enabled), output order preserved across the wrap.
REQ-027 With VC0 empty, read and write VC0 with 0x1234 -> next cycle empty_o[0]=0 and data_o=0x1234 (read_vc_i=0); with VC0 full plus read and write -> full_o[0]=0 and the head is popped.
REQ-028 SIZE=5, NUM_VC=3: write 7 and read 7 on VC2 -> correct wrap at index 4; a write or read with VC index 3 is ignored.
REQ-029 Assert rst=0 for one cycle while VC0 and VC1 are half full -> full_o=0 and empty_o=all-1 on the next cycle; a following read is ignored.
